mandelbrot_pixel_collector: RTL and testbench
=============================================

Name: mandelbrot_pixel_collector

Overview:
- Consumer end of the mandelbrot core's run/running/ctr_out pixel handshake.
- Requests one pixel at a time from the core and captures each 4-bit iteration code when the pixel completes.
- Packs two codes per byte and emits the bytes on a valid/ready stream with start-of-frame and end-of-line markers.
- Sits between the mandelbrot core and the output pin/serializer logic; throttles the core when the downstream stalls.

Parameters:
- WIDTH, 320, pixels per line; must be even.
- HEIGHT, 240, lines per frame.
- FIFO_DEPTH, 2, output byte buffer entries; must be at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- continuous  in  1  restart the next frame automatically after frame_done.
- core_run  out  1  single-cycle pixel request to the core.
- core_running  in  1  core busy computing the current pixel.
- core_finished  in  1  core is at frame boundary; its coordinates will reset on the next run.
- core_ctr  in  4  pixel code; valid in the first cycle core_running is low after a pixel.
- m_data  out  8  packed byte: [3:0] = even-x pixel, [7:4] = odd-x pixel.
- m_valid  out  1  byte available.
- m_ready  in  1  downstream accepts the byte; a transfer occurs when m_valid && m_ready.
- m_sof  out  1  current byte holds pixel (0,0).
- m_eol  out  1  current byte holds pixel x = WIDTH-1.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel is captured.
- sync_err  out  1  sticky flag; core_finished was low at frame start. Cleared by reset only.

Behaviour:
- Reset values: all outputs 0; FIFO empty; x = 0, y = 0; nibble register = 0; state IDLE.
- State machine:
  - IDLE: on start, or on continuous after a frame, check core_finished; if it is 0, set sync_err (proceed anyway). Clear x and y, go to REQ.
  - REQ: enter only when the FIFO count is below FIFO_DEPTH; otherwise hold in REQ with core_run = 0. core_run = 1 for exactly one cycle, then go to WAIT_START.
  - WAIT_START: wait for core_running = 1, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: on the first cycle core_running = 0, capture core_ctr and go to PACK.
  - PACK (one cycle):
    - If x is even, store the code in the low nibble register.
    - If x is odd, push {code, low_nibble} with sof = (x == 1 && y == 0) and eol = (x == WIDTH-1).
    - Advance x; at x = WIDTH-1, wrap x to 0 and increment y.
    - If the pixel just packed was (WIDTH-1, HEIGHT-1), pulse frame_done and go to IDLE. Otherwise go to REQ.
- Latency: core_run to core_running = 1 cycle, set by the core. Captured code to m_valid = 1 cycle when the FIFO was empty (push occurs in PACK, registered output).
- Throttling: at most one pixel is in flight. Because REQ requires free space, a push never finds the FIFO full; no data is dropped.
- FIFO:
  - Synchronous, first-word fall-through; m_data, m_sof and m_eol come from the head entry.
  - A push and a pop in the same cycle leave the count unchanged.
  - A pop when empty cannot occur, since m_valid = 0.
- m_valid, m_data, m_sof and m_eol must stay stable while m_valid && !m_ready.
- frame_done can pulse while bytes are still buffered. The stream ends at the byte carrying m_eol on line HEIGHT-1.
- continuous = 1: the IDLE to REQ transition happens the cycle after frame_done; start is ignored.
- start during a frame is ignored; there is no abort. Reset is the only abort: the FIFO is flushed, the state returns to IDLE, and the core must also be reset.
- Width rules: x uses $clog2(WIDTH) bits, y uses $clog2(HEIGHT) bits; arithmetic is unsigned.

Decomposition:
- Shared package mandelbrot_pkg:
  - state enum {IDLE, REQ, WAIT_START, WAIT_DONE, PACK};
  - PIXEL_BITS = 4;
  - BYTE_BITS = 8.
- Sub-module pixel_byte_fifo (parameterised depth, 10-bit entries {eol, sof, data}), with count output for the REQ gate.

Test Plan (WIDTH = 4, HEIGHT = 2, behavioural core model with 3-cycle pixels returning codes 1..8):
1. Reset, start pulse, m_ready = 1 -> exactly 8 core_run pulses. Bytes 0x21(sof), 0x43(eol), 0x65, 0x87(eol). frame_done once; busy back to 0.
2. m_ready = 0 throughout -> after 2 bytes are buffered, core_run stays 0 with state in REQ. Raising m_ready releases 0x21, then 0x43, with no byte lost or duplicated.
3. m_ready toggling every cycle while m_valid = 1 -> m_data and m_sof stay stable across stalled cycles; the byte order is unchanged.
4. continuous = 1 -> the second frame starts the cycle after frame_done. Byte 5 carries m_sof = 1 and core_finished = 1 at the first run; sync_err stays 0.
5. Core model holding core_finished = 0 at start -> sync_err = 1 and remains set through the frame; the data stream is still produced.
6. rst_n asserted during WAIT_DONE with 1 byte buffered -> m_valid = 0, busy = 0, core_run = 0 immediately. A subsequent start begins a new frame with m_sof on the first byte.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the mandelbrot pixel collector slice.
package mandelbrot_pkg;

    localparam int PIXEL_BITS = 4;
    localparam int BYTE_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_START,
        WAIT_DONE,
        PACK
    } state_e;

    // One buffered output byte plus its stream markers, packed as {eol, sof, data}.
    typedef struct packed {
        logic                 eol;
        logic                 sof;
        logic [BYTE_BITS-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/pixel_byte_fifo.sv
// First-word fall-through byte buffer between the pixel packer and the output stream.
module pixel_byte_fifo
    import mandelbrot_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fifo_entry_t                push_entry,
    input  logic                       pop,
    output fifo_entry_t                head,
    output logic                       not_empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    fifo_entry_t   mem_q [DEPTH];
    fifo_entry_t   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign count     = count_q;

endmodule

// File: rtl/mandelbrot_pixel_collector.sv
// Requests pixels one at a time from the mandelbrot core, packs two 4-bit codes per
// byte and streams the bytes out with start-of-frame / end-of-line markers.
module mandelbrot_pixel_collector
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  continuous,
    output logic                  core_run,
    input  logic                  core_running,
    input  logic                  core_finished,
    input  logic [PIXEL_BITS-1:0] core_ctr,
    output logic [BYTE_BITS-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  sync_err
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    state_e                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [PIXEL_BITS-1:0] code_q, code_d;
    logic [PIXEL_BITS-1:0] low_q, low_d;
    logic                  frame_done_q, frame_done_d;
    logic                  sync_err_q, sync_err_d;

    logic                  push;
    logic                  pop;
    fifo_entry_t           push_entry;
    fifo_entry_t           head;
    logic                  fifo_not_empty;
    logic [CW-1:0]         fifo_count;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        code_d       = code_q;
        low_d        = low_q;
        frame_done_d = 1'b0;
        sync_err_d   = sync_err_q;
        core_run     = 1'b0;
        push         = 1'b0;
        push_entry   = '0;
        case (state_q)
            IDLE: begin
                if (start || (continuous && frame_done_q)) begin
                    if (!core_finished) begin
                        sync_err_d = 1'b1;
                    end
                    x_d     = '0;
                    y_d     = '0;
                    state_d = REQ;
                end
            end
            // A request is only issued when the buffer can take the byte it may produce.
            REQ: begin
                if (fifo_count < CW'(FIFO_DEPTH)) begin
                    core_run = 1'b1;
                    state_d  = WAIT_START;
                end
            end
            WAIT_START: begin
                if (core_running) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!core_running) begin
                    code_d  = core_ctr;
                    state_d = PACK;
                end
            end
            PACK: begin
                if (!x_q[0]) begin
                    low_d = code_q;
                end else begin
                    push            = 1'b1;
                    push_entry.data = {code_q, low_q};
                    push_entry.sof  = (x_q == XW'(1)) && (y_q == '0);
                    push_entry.eol  = (x_q == X_LAST);
                end
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d          = '0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        y_d     = y_q + YW'(1);
                        state_d = REQ;
                    end
                end else begin
                    x_d     = x_q + XW'(1);
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            code_q       <= '0;
            low_q        <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            code_q       <= code_d;
            low_q        <= low_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    pixel_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head),
        .not_empty (fifo_not_empty),
        .count     (fifo_count)
    );

    assign pop        = fifo_not_empty && m_ready;
    assign m_valid    = fifo_not_empty;
    assign m_data     = head.data;
    assign m_sof      = head.sof;
    assign m_eol      = head.eol;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_mandelbrot_pixel_collector.sv
// Directed bench for the pixel collector on a 4x2 frame with a 3-cycle behavioural core.
module tb_mandelbrot_pixel_collector;

    localparam int WIDTH      = 4;
    localparam int HEIGHT     = 2;
    localparam int FIFO_DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       core_run;
    logic       core_running;
    logic       core_finished;
    logic [3:0] core_ctr;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       m_sof;
    logic       m_eol;
    logic       busy;
    logic       frame_done;
    logic       sync_err;

    int checks = 0;
    int failures = 0;

    // {eol, sof, data} of the four bytes of one frame; codes run 1..8 in raster order.
    logic [9:0] exp_frame [4] = '{10'h121, 10'h243, 10'h065, 10'h287};

    mandelbrot_pixel_collector #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .continuous   (continuous),
        .core_run     (core_run),
        .core_running (core_running),
        .core_finished(core_finished),
        .core_ctr     (core_ctr),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_sof        (m_sof),
        .m_eol        (m_eol),
        .busy         (busy),
        .frame_done   (frame_done),
        .sync_err     (sync_err)
    );

    always #5 clk = ~clk;

    // Core model: running rises the cycle after run, stays high 3 cycles, then presents the code.
    int   run_cnt;
    int   pix_idx;
    logic force_unfinished = 1'b0;

    assign core_finished = (pix_idx == 0) && !force_unfinished;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt      <= 0;
            core_running <= 1'b0;
            core_ctr     <= 4'd0;
            pix_idx      <= 0;
        end else if (core_run && run_cnt == 0) begin
            run_cnt      <= 3;
            core_running <= 1'b1;
        end else if (run_cnt > 0) begin
            run_cnt <= run_cnt - 1;
            if (run_cnt == 1) begin
                core_running <= 1'b0;
                core_ctr     <= 4'(pix_idx + 1);
                pix_idx      <= (pix_idx + 1) % 8;
            end
        end
    end

    logic [9:0] rx_q [$];
    int run_pulses = 0;
    int fd_seen = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_run) run_pulses <= run_pulses + 1;
            if (frame_done) fd_seen <= fd_seen + 1;
            if (m_valid && m_ready) rx_q.push_back({m_eol, m_sof, m_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        force_unfinished = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (fd_seen >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({core_run, m_valid, m_sof, m_eol, busy, frame_done, sync_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl actual=%b required=0000000",
                     {core_run, m_valid, m_sof, m_eol, busy, frame_done, sync_err});
        end
        checks++;
        if (m_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data actual=%h required=00", m_data);
        end
    endtask

    task automatic test_single_frame();
        int b0, p0, f0;
        bit ok;
        do_reset();
        m_ready = 1'b1;
        b0 = rx_q.size();
        p0 = run_pulses;
        f0 = fd_seen;
        pulse_start();
        wait_frames(f0 + 1, 300, ok);
        repeat (6) tick();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_timeout actual=no_frame_done required=frame_done");
        end
        checks++;
        if (run_pulses - p0 !== 8) begin
            failures++;
            $display("FAIL single_run_pulses actual=%0d required=8", run_pulses - p0);
        end
        checks++;
        if (fd_seen - f0 !== 1) begin
            failures++;
            $display("FAIL single_frame_done actual=%0d required=1", fd_seen - f0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_end actual=%b required=0", busy);
        end
        checks++;
        if (rx_q.size() - b0 !== 4) begin
            failures++;
            $display("FAIL single_byte_count actual=%0d required=4", rx_q.size() - b0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b0 + i >= rx_q.size() || rx_q[b0 + i] !== exp_frame[i]) begin
                failures++;
                $display("FAIL single_byte%0d actual=%h required=%h", i,
                         (b0 + i < rx_q.size()) ? rx_q[b0 + i] : 10'h3ff, exp_frame[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int b0, p0, f0;
        bit ok;
        do_reset();
        b0 = rx_q.size();
        p0 = run_pulses;
        f0 = fd_seen;
        pulse_start();
        repeat (100) tick();
        checks++;
        if (run_pulses - p0 !== 4) begin
            failures++;
            $display("FAIL bp_held_pulses actual=%0d required=4", run_pulses - p0);
        end
        checks++;
        if ({core_run, busy, m_valid} !== 3'b011) begin
            failures++;
            $display("FAIL bp_held_ctrl actual=%b required=011", {core_run, busy, m_valid});
        end
        checks++;
        if ({m_eol, m_sof, m_data} !== 10'h121) begin
            failures++;
            $display("FAIL bp_head actual=%h required=121", {m_eol, m_sof, m_data});
        end
        m_ready = 1'b1;
        wait_frames(f0 + 1, 300, ok);
        repeat (6) tick();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_timeout actual=no_frame_done required=frame_done");
        end
        checks++;
        if (rx_q.size() - b0 !== 4 || run_pulses - p0 !== 8) begin
            failures++;
            $display("FAIL bp_counts actual=bytes%0d_runs%0d required=bytes4_runs8",
                     rx_q.size() - b0, run_pulses - p0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b0 + i >= rx_q.size() || rx_q[b0 + i] !== exp_frame[i]) begin
                failures++;
                $display("FAIL bp_byte%0d actual=%h required=%h", i,
                         (b0 + i < rx_q.size()) ? rx_q[b0 + i] : 10'h3ff, exp_frame[i]);
            end
        end
    endtask

    task automatic test_stall_toggle();
        int b0, f0;
        logic prev_valid, prev_ready;
        logic [9:0] prev_bits;
        do_reset();
        b0 = rx_q.size();
        f0 = fd_seen;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_bits = '0;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            if (prev_valid && !prev_ready) begin
                checks++;
                if ({m_valid, m_eol, m_sof, m_data} !== {1'b1, prev_bits}) begin
                    failures++;
                    $display("FAIL stall_hold actual=%h required=%h",
                             {m_valid, m_eol, m_sof, m_data}, {1'b1, prev_bits});
                end
            end
            prev_valid = m_valid;
            prev_bits = {m_eol, m_sof, m_data};
            m_ready = ~m_ready;
            prev_ready = m_ready;
            tick();
            if (rx_q.size() - b0 >= 4 && fd_seen > f0) break;
        end
        m_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (fd_seen - f0 !== 1) begin
            failures++;
            $display("FAIL stall_frame_done actual=%0d required=1", fd_seen - f0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b0 + i >= rx_q.size() || rx_q[b0 + i] !== exp_frame[i]) begin
                failures++;
                $display("FAIL stall_byte%0d actual=%h required=%h", i,
                         (b0 + i < rx_q.size()) ? rx_q[b0 + i] : 10'h3ff, exp_frame[i]);
            end
        end
    endtask

    task automatic test_continuous();
        int b0, p0, f0;
        bit ok;
        do_reset();
        m_ready = 1'b1;
        continuous = 1'b1;
        b0 = rx_q.size();
        p0 = run_pulses;
        f0 = fd_seen;
        pulse_start();
        wait_frames(f0 + 1, 300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL cont_timeout1 actual=no_frame_done required=frame_done");
        end
        // One cycle after the frame_done pulse the collector must already be requesting.
        checks++;
        if ({frame_done, busy, core_run, core_finished} !== 4'b0111) begin
            failures++;
            $display("FAIL cont_restart actual=%b required=0111",
                     {frame_done, busy, core_run, core_finished});
        end
        continuous = 1'b0;
        wait_frames(f0 + 2, 300, ok);
        repeat (6) tick();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL cont_timeout2 actual=no_frame_done required=frame_done");
        end
        checks++;
        if (rx_q.size() - b0 !== 8 || run_pulses - p0 !== 16) begin
            failures++;
            $display("FAIL cont_counts actual=bytes%0d_runs%0d required=bytes8_runs16",
                     rx_q.size() - b0, run_pulses - p0);
        end
        checks++;
        if (b0 + 4 >= rx_q.size() || rx_q[b0 + 4] !== 10'h121) begin
            failures++;
            $display("FAIL cont_byte4_sof actual=%h required=121",
                     (b0 + 4 < rx_q.size()) ? rx_q[b0 + 4] : 10'h3ff);
        end
        checks++;
        if (b0 + 7 >= rx_q.size() || rx_q[b0 + 7] !== 10'h287) begin
            failures++;
            $display("FAIL cont_byte7_eol actual=%h required=287",
                     (b0 + 7 < rx_q.size()) ? rx_q[b0 + 7] : 10'h3ff);
        end
        checks++;
        if ({sync_err, busy} !== 2'b00) begin
            failures++;
            $display("FAIL cont_end_state actual=%b required=00", {sync_err, busy});
        end
    endtask

    task automatic test_sync_err();
        int b0, f0;
        bit ok;
        do_reset();
        force_unfinished = 1'b1;
        m_ready = 1'b1;
        b0 = rx_q.size();
        f0 = fd_seen;
        checks++;
        if (sync_err !== 1'b0) begin
            failures++;
            $display("FAIL sync_before actual=%b required=0", sync_err);
        end
        pulse_start();
        checks++;
        if (sync_err !== 1'b1) begin
            failures++;
            $display("FAIL sync_set actual=%b required=1", sync_err);
        end
        wait_frames(f0 + 1, 300, ok);
        repeat (6) tick();
        checks++;
        if (!ok || sync_err !== 1'b1) begin
            failures++;
            $display("FAIL sync_sticky actual=done%0b_err%b required=done1_err1", ok, sync_err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b0 + i >= rx_q.size() || rx_q[b0 + i] !== exp_frame[i]) begin
                failures++;
                $display("FAIL sync_byte%0d actual=%h required=%h", i,
                         (b0 + i < rx_q.size()) ? rx_q[b0 + i] : 10'h3ff, exp_frame[i]);
            end
        end
        force_unfinished = 1'b0;
    endtask

    task automatic test_reset_abort();
        int b0, f0;
        bit ok;
        do_reset();
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            if (m_valid) break;
            tick();
        end
        checks++;
        if (m_valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_first_byte actual=%b required=1", m_valid);
        end
        // Byte 0 buffered, pixel 2 requested: two more cycles land in WAIT_DONE.
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, busy, core_run} !== 3'b000) begin
            failures++;
            $display("FAIL abort_outputs actual=%b required=000", {m_valid, busy, core_run});
        end
        tick();
        rst_n = 1'b1;
        tick();
        m_ready = 1'b1;
        b0 = rx_q.size();
        f0 = fd_seen;
        pulse_start();
        wait_frames(f0 + 1, 300, ok);
        repeat (6) tick();
        checks++;
        if (!ok || rx_q.size() - b0 !== 4) begin
            failures++;
            $display("FAIL abort_restart actual=done%0b_bytes%0d required=done1_bytes4",
                     ok, rx_q.size() - b0);
        end
        checks++;
        if (b0 >= rx_q.size() || rx_q[b0] !== 10'h121) begin
            failures++;
            $display("FAIL abort_first_sof actual=%h required=121",
                     (b0 < rx_q.size()) ? rx_q[b0] : 10'h3ff);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_stall_toggle();
        test_continuous();
        test_sync_err();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
